// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter: round-robin AR grant locked until handshake,
// per-master outstanding-burst limit, R beats routed back by the ID MSB.
module axi_rd_arbiter #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 32,
    parameter int MAX_OSTD   = 4
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    input  logic [AXI_ID_W-1:0]   m0_arid,
    input  logic [3:0]            m0_arlen,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    output logic [AXI_ID_W-1:0]   m0_rid,
    output logic [1:0]            m0_rresp,
    output logic [AXI_DATA_W-1:0] m0_rdata,
    output logic                  m0_rlast,

    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    input  logic [AXI_ID_W-1:0]   m1_arid,
    input  logic [3:0]            m1_arlen,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [AXI_ID_W-1:0]   m1_rid,
    output logic [1:0]            m1_rresp,
    output logic [AXI_DATA_W-1:0] m1_rdata,
    output logic                  m1_rlast,

    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [AXI_ID_W:0]     s_arid,
    output logic [3:0]            s_arlen,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [AXI_ID_W:0]     s_rid,
    input  logic [1:0]            s_rresp,
    input  logic [AXI_DATA_W-1:0] s_rdata,
    input  logic                  s_rlast,

    output logic                  err_unexp_r
);

    localparam int               CNT_W   = $clog2(MAX_OSTD) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OSTD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] ost_cnt_q [2];
    logic [CNT_W-1:0] ost_cnt_d [2];
    logic             err_unexp_r_q, err_unexp_r_d;

    logic [1:0] elig;
    logic [1:0] ar_grant;
    logic [1:0] r_sel_n;
    logic [1:0] ost_inc;
    logic [1:0] ost_dec;
    logic       ar_hs;
    logic       r_hs;
    logic       r_sel;

    // AR side: outputs decode from the registered grant, so IDLE drives nothing.
    always_comb begin
        elig[0]     = m0_arvalid && (ost_cnt_q[0] < MAX_CNT);
        elig[1]     = m1_arvalid && (ost_cnt_q[1] < MAX_CNT);
        ar_grant[0] = (state_q == LOCK0);
        ar_grant[1] = (state_q == LOCK1);
        s_arvalid   = (ar_grant[0] & m0_arvalid) | (ar_grant[1] & m1_arvalid);
        m0_arready  = ar_grant[0] & s_arready;
        m1_arready  = ar_grant[1] & s_arready;
        s_arid      = ar_grant[1] ? {1'b1, m1_arid} : {1'b0, m0_arid};
        s_arlen     = ar_grant[1] ? m1_arlen : m0_arlen;
        ar_hs       = s_arvalid & s_arready;
    end

    always_comb begin
        r_sel     = s_rid[AXI_ID_W];
        r_sel_n   = {r_sel, ~r_sel};
        m0_rvalid = s_rvalid & ~r_sel;
        m1_rvalid = s_rvalid & r_sel;
        s_rready  = r_sel ? m1_rready : m0_rready;
        m0_rid    = s_rid[AXI_ID_W-1:0];
        m1_rid    = s_rid[AXI_ID_W-1:0];
        m0_rresp  = s_rresp;
        m1_rresp  = s_rresp;
        m0_rdata  = s_rdata;
        m1_rdata  = s_rdata;
        m0_rlast  = s_rlast;
        m1_rlast  = s_rlast;
        r_hs      = s_rvalid & s_rready;
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        err_unexp_r_d = err_unexp_r_q;
        ost_inc       = ar_grant & {2{ar_hs}};
        ost_dec       = r_sel_n & {2{r_hs & s_rlast}};

        unique case (state_q)
            IDLE: begin
                if (elig == 2'b11) state_d = rr_ptr_q ? LOCK1 : LOCK0;
                else if (elig[0])  state_d = LOCK0;
                else if (elig[1])  state_d = LOCK1;
            end
            LOCK0: begin
                if (ar_hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = 1'b1;
                end
            end
            LOCK1: begin
                if (ar_hs) begin
                    state_d  = IDLE;
                    rr_ptr_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A beat for a master with nothing outstanding flags an error and never wraps the count.
        for (int n = 0; n < 2; n++) begin
            ost_cnt_d[n] = ost_cnt_q[n];
            if (ost_inc[n] && !ost_dec[n])
                ost_cnt_d[n] = ost_cnt_q[n] + CNT_W'(1);
            else if (ost_dec[n] && !ost_inc[n] && (ost_cnt_q[n] != '0))
                ost_cnt_d[n] = ost_cnt_q[n] - CNT_W'(1);
            if (r_hs && r_sel_n[n] && (ost_cnt_q[n] == '0))
                err_unexp_r_d = 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 1'b0;
            ost_cnt_q[0]  <= '0;
            ost_cnt_q[1]  <= '0;
            err_unexp_r_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            ost_cnt_q[0]  <= ost_cnt_d[0];
            ost_cnt_q[1]  <= ost_cnt_d[1];
            err_unexp_r_q <= err_unexp_r_d;
        end
    end

    assign err_unexp_r = err_unexp_r_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: inputs change 1ns after each rising edge,
// outputs are compared 1ns later, well clear of the next edge.
module tb_axi_rd_arbiter;

    localparam int ID_W   = 4;
    localparam int DATA_W = 32;

    logic              aclk;
    logic              areset;
    logic              m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [ID_W-1:0]   m0_arid, m0_rid;
    logic [3:0]        m0_arlen;
    logic [1:0]        m0_rresp;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [ID_W-1:0]   m1_arid, m1_rid;
    logic [3:0]        m1_arlen;
    logic [1:0]        m1_rresp;
    logic [DATA_W-1:0] m1_rdata;
    logic              s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [ID_W:0]     s_arid, s_rid;
    logic [3:0]        s_arlen;
    logic [1:0]        s_rresp;
    logic [DATA_W-1:0] s_rdata;
    logic              err_unexp_r;

    int checks;
    int failures;

    axi_rd_arbiter #(.AXI_ID_W(ID_W), .AXI_DATA_W(DATA_W), .MAX_OSTD(4)) dut (
        .aclk(aclk), .areset(areset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rid(m0_rid), .m0_rresp(m0_rresp),
        .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rid(m1_rid), .m1_rresp(m1_rresp),
        .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rresp(s_rresp),
        .s_rdata(s_rdata), .s_rlast(s_rlast),
        .err_unexp_r(err_unexp_r)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        areset     = 1'b1;
        m0_arvalid = 1'b0; m0_arid = '0; m0_arlen = '0; m0_rready = 1'b0;
        m1_arvalid = 1'b0; m1_arid = '0; m1_arlen = '0; m1_rready = 1'b0;
        s_arready  = 1'b1;
        // R path must stay live while reset is held
        s_rvalid   = 1'b1; s_rid = 5'h12; s_rresp = 2'b10; s_rdata = 32'hA5A5_0001; s_rlast = 1'b1;
        m1_rready  = 1'b1;

        cyc();
        check("rst_s_arvalid", s_arvalid, 0);
        check("rst_m0_arready", m0_arready, 0);
        check("rst_m1_arready", m1_arready, 0);
        check("rst_err", err_unexp_r, 0);
        check("rst_ost0", dut.ost_cnt_q[0], 0);
        check("rst_ost1", dut.ost_cnt_q[1], 0);
        check("rst_m1_rvalid", m1_rvalid, 1);
        check("rst_m1_rdata", m1_rdata, 32'hA5A5_0001);
        check("rst_s_rready", s_rready, 1);
        s_rvalid = 1'b0; s_rlast = 1'b0; m1_rready = 1'b0;

        // single request: latency 1 cycle, ID prefixed with master index
        cyc();
        areset = 1'b0;
        m0_arvalid = 1'b1; m0_arid = 4'd3; m0_arlen = 4'd7;
        #1;
        check("single_req_cycle_s_arvalid", s_arvalid, 0);
        cyc();
        check("single_s_arvalid", s_arvalid, 1);
        check("single_s_arid", s_arid, 5'b0_0011);
        check("single_s_arlen", s_arlen, 7);
        check("single_m0_arready", m0_arready, 1);
        check("single_m1_arready", m1_arready, 0);
        cyc();
        m0_arvalid = 1'b0;
        #1;
        check("single_m0_arready_drop", m0_arready, 0);
        check("single_ost0", dut.ost_cnt_q[0], 1);

        // last beat back to m0 retires the burst
        s_rvalid = 1'b1; s_rid = 5'h03; s_rlast = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b01;
        m0_rready = 1'b1;
        #1;
        check("r0_m0_rvalid", m0_rvalid, 1);
        check("r0_m1_rvalid", m1_rvalid, 0);
        check("r0_m0_rid", m0_rid, 3);
        check("r0_m1_rdata_bcast", m1_rdata, 32'hDEAD_BEEF);
        check("r0_m1_rresp_bcast", m1_rresp, 2'b01);
        check("r0_s_rready", s_rready, 1);
        cyc();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        check("r0_ost0", dut.ost_cnt_q[0], 0);
        check("r0_err", err_unexp_r, 0);

        // routing follows s_rid MSB and the selected master's rready
        s_rid = 5'b1_0010; s_rvalid = 1'b1; m1_rready = 1'b0; m0_rready = 1'b1;
        #1;
        check("route_m1_rvalid", m1_rvalid, 1);
        check("route_m1_rid", m1_rid, 2);
        check("route_m0_rvalid", m0_rvalid, 0);
        check("route_s_rready_lo", s_rready, 0);
        m1_rready = 1'b1;
        #1;
        check("route_s_rready_hi", s_rready, 1);
        s_rvalid = 1'b0; m1_rready = 1'b0;

        // unexpected rlast for m0: sticky error, no counter wrap
        s_rid = 5'h00; s_rvalid = 1'b1; s_rlast = 1'b1; m0_rready = 1'b1;
        cyc();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        check("unexp_err_set", err_unexp_r, 1);
        check("unexp_ost0_nowrap", dut.ost_cnt_q[0], 0);
        cyc();
        check("unexp_err_sticky", err_unexp_r, 1);

        // async reset clears the flag without a clock edge
        areset = 1'b1;
        #1;
        check("areset_err_clr", err_unexp_r, 0);
        areset = 1'b0;

        // contention: m0, m1, m0, m1, one handshake every 2 cycles
        m0_arvalid = 1'b1; m0_arid = 4'd1; m0_arlen = 4'd0;
        m1_arvalid = 1'b1; m1_arid = 4'd9; m1_arlen = 4'd1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("rr_m0_arready", m0_arready, (k % 2 == 0));
            check("rr_m1_arready", m1_arready, (k % 2 == 1));
            check("rr_s_arid", s_arid, (k % 2 == 1) ? 5'h19 : 5'h01);
            check("rr_s_arlen", s_arlen, (k % 2 == 1) ? 1 : 0);
            cyc();
            if (k == 3) begin
                m0_arvalid = 1'b0;
                m1_arvalid = 1'b0;
            end
            check("rr_gap_s_arvalid", s_arvalid, 0);
        end
        check("rr_ost0", dut.ost_cnt_q[0], 2);
        check("rr_ost1", dut.ost_cnt_q[1], 2);

        // AR handshake and rlast for m0 in the same cycle cancel out
        m0_arvalid = 1'b1; m0_arid = 4'd4;
        cyc();
        check("simul_m0_arready", m0_arready, 1);
        s_rvalid = 1'b1; s_rid = 5'h01; s_rlast = 1'b1; m0_rready = 1'b1;
        cyc();
        m0_arvalid = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        check("simul_ost0", dut.ost_cnt_q[0], 2);

        // fill m1 to the limit, then the extra request must wait
        m1_arvalid = 1'b1; m1_arid = 4'd6;
        repeat (2) begin
            cyc();
            cyc();
        end
        check("limit_ost1_full", dut.ost_cnt_q[1], 4);
        repeat (3) begin
            cyc();
            check("limit_blocked_arready", m1_arready, 0);
            check("limit_blocked_s_arvalid", s_arvalid, 0);
        end
        s_rvalid = 1'b1; s_rid = 5'h16; s_rlast = 1'b1; m1_rready = 1'b1;
        cyc();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        #1;
        check("limit_freed_not_yet", s_arvalid, 0);
        check("limit_ost1_dec", dut.ost_cnt_q[1], 3);
        cyc();
        check("limit_granted_arready", m1_arready, 1);
        check("limit_granted_s_arvalid", s_arvalid, 1);

        // arvalid dropped while locked: grant holds, s_arvalid follows it low
        m1_arvalid = 1'b0;
        #1;
        check("drop_s_arvalid", s_arvalid, 0);
        cyc();
        check("drop_still_locked", m1_arready, 1);
        check("drop_s_arvalid_held", s_arvalid, 0);
        m1_arvalid = 1'b1;
        cyc();
        m1_arvalid = 1'b0;
        #1;
        check("drop_ost1_refill", dut.ost_cnt_q[1], 4);

        // reset in the middle of a pending LOCK1 request
        s_arready = 1'b0;
        s_rvalid = 1'b1; s_rid = 5'h16; s_rlast = 1'b1; m1_rready = 1'b1;
        m1_arvalid = 1'b1;
        cyc();
        s_rvalid = 1'b0; s_rlast = 1'b0;
        cyc();
        check("midlock_s_arvalid", s_arvalid, 1);
        check("midlock_m1_arready", m1_arready, 0);
        areset = 1'b1;
        #1;
        check("midlock_rst_s_arvalid", s_arvalid, 0);
        check("midlock_rst_ost0", dut.ost_cnt_q[0], 0);
        check("midlock_rst_ost1", dut.ost_cnt_q[1], 0);
        check("midlock_rst_err", err_unexp_r, 0);
        areset = 1'b0;
        m1_arvalid = 1'b0;

        // a stale non-last beat after reset release is unexpected
        s_rvalid = 1'b1; s_rid = 5'h01; s_rlast = 1'b0; m0_rready = 1'b1;
        cyc();
        s_rvalid = 1'b0;
        #1;
        check("stale_beat_err", err_unexp_r, 1);
        check("stale_beat_ost0", dut.ost_cnt_q[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 The block SHALL expose these parameters: AXI_ID_W, default 4, upstream ID width; AXI_DATA_W, default 32, R data width; MAX_OSTD, default 4, maximum outstanding read bursts per master (power of two, ≥1).
REQ-002 aclk  input  1  clock; all state updates on rising edge.
REQ-003 areset  input  1  asynchronous, active-high reset.
REQ-004 mN_arvalid (N=0,1)  input  1  master N AR request valid.
REQ-005 mN_arready  output  1  master N AR accepted.
REQ-006 mN_arid  input  AXI_ID_W  master N AR ID.
REQ-007 mN_arlen  input  4  master N burst length minus one.
REQ-008 mN_rvalid  output  1  R beat valid to master N.
REQ-009 mN_rready  input  1  master N R ready.
REQ-010 mN_rid / mN_rresp / mN_rdata / mN_rlast  output  AXI_ID_W / 2 / AXI_DATA_W / 1  R payload to master N.
REQ-011 s_arvalid / s_arready  output / input  1 / 1  downstream AR handshake.
REQ-012 s_arid / s_arlen  output  AXI_ID_W+1 / 4  downstream AR ID and length.
REQ-013 s_rvalid / s_rready  input / output  1 / 1  downstream R handshake.
REQ-014 s_rid / s_rresp / s_rdata / s_rlast  input  AXI_ID_W+1 / 2 / AXI_DATA_W / 1  downstream R payload.
REQ-015 err_unexp_r  output  1  sticky flag for an R beat routed to a master with no outstanding burst.

Function
REQ-016 The AR FSM SHALL have states IDLE, LOCK0 and LOCK1.
REQ-017 A master N SHALL be eligible when mN_arvalid=1 and ost_cnt[N] < MAX_OSTD.
REQ-018 In IDLE, on a rising edge, the FSM SHALL go to LOCKn for the single eligible master; if both are eligible it SHALL go to LOCK of rr_ptr; if neither is eligible it SHALL stay in IDLE.
REQ-019 In IDLE, s_arvalid SHALL be 0 and both mN_arready SHALL be 0; request-to-s_arvalid latency SHALL be exactly 1 cycle.
REQ-020 In LOCKn:
  - s_arvalid = mn_arvalid
  - mn_arready = s_arready
  - s_arid = {n, mn_arid}
  - s_arlen = mn_arlen
  - the other master's arready = 0
REQ-021 The FSM SHALL return from LOCKn to IDLE on s_arvalid & s_arready, and rr_ptr SHALL then become 1-n; otherwise it SHALL hold LOCKn, so the grant is stable while a request is pending.
REQ-022 Maximum AR throughput SHALL be one accepted request per 2 cycles.
REQ-023 R routing SHALL be combinational with sel = s_rid[AXI_ID_W]:
  - m_sel_rvalid = s_rvalid; the other master's rvalid = 0
  - s_rready = m_sel_rready
  - mN_rid = s_rid[AXI_ID_W-1:0] for both masters
  - rresp, rdata and rlast broadcast to both masters
REQ-024 ost_cnt[N], width clog2(MAX_OSTD)+1, SHALL update as follows:
  - +1 on an AR handshake in LOCKN
  - −1 on an s_rvalid & s_rready & s_rlast beat with sel=N
  - unchanged when both events occur in the same cycle
REQ-025 Eligibility SHALL use the registered ost_cnt only; a same-cycle rlast does not free a slot until the next cycle.
REQ-026 An rlast handshake for master N while ost_cnt[N]=0 SHALL set err_unexp_r and SHALL leave ost_cnt[N] at 0 (no wrap).
REQ-027 A non-last R beat for master N while ost_cnt[N]=0 SHALL also set err_unexp_r.
REQ-028 ost_cnt[N] SHALL never exceed MAX_OSTD; REQ-017 guarantees this.
REQ-029 mN_arvalid deasserting while in LOCKN (protocol violation) SHALL leave the FSM in LOCKN with s_arvalid=0.

Reset
REQ-030 While areset=1, independent of aclk, the block SHALL hold: FSM=IDLE, rr_ptr=0, ost_cnt[0]=ost_cnt[1]=0, err_unexp_r=0.
REQ-031 Reset SHALL force s_arvalid=0 and mN_arready=0; R outputs follow their inputs combinationally.
REQ-032 Reset asserted mid-burst SHALL discard all outstanding tracking; in-flight R beats after reset release set err_unexp_r.

Verification
REQ-033 Single request: m0_arvalid=1, arid=3, arlen=7, s_arready=1 -> s_arvalid high 1 cycle later with s_arid=5'b0_0011 and s_arlen=7; m0_arready pulses once; ost_cnt[0]=1.
REQ-034 Contention: both masters valid from reset, s_arready=1 -> grants in order m0, m1, m0, m1; one handshake every 2 cycles.
REQ-035 Outstanding limit, MAX_OSTD=4: m1 issues 4 ARs with no R -> 5th request never granted; one s_rlast beat with s_rid[4]=1 -> 5th granted within 2 cycles.
REQ-036 Routing: s_rid=5'b1_0010, s_rvalid=1, m1_rready=0 -> m1_rvalid=1, m1_rid=2, m0_rvalid=0, s_rready=0; m1_rready=1 -> s_rready=1.
REQ-037 Simultaneous events: AR handshake for m0 and m0 rlast handshake in the same cycle with ost_cnt[0]=2 -> ost_cnt[0] stays 2.
REQ-038 Error and reset: rlast for m0 with ost_cnt[0]=0 -> err_unexp_r=1 and stays 1; areset pulse mid-LOCK1 -> FSM=IDLE, err_unexp_r=0, counters 0 immediately.
